// File: rtl/matrix_operand_loader_pkg.sv
// Shared types and sizing helpers for the matrix operand loader.
package matrix_operand_loader_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must hold 0..DATA_W+1, the top value marking overrun.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 2);
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_DATA_W);

endpackage

// File: rtl/matrix_operand_loader_pin_sync.sv
// Multi-flop pin synchroniser with a history flop for rise/fall event pulses.
module matrix_operand_loader_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~hist_q;
    assign fall_c = ~level & hist_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial operand receiver: synchronises a 3-wire link and commits only complete,
// correctly sized frames to the registered operand feeding the two matrix stages.
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sclk_i,
    input  logic              sdi_i,
    input  logic              cs_n_i,
    output logic [DATA_W-1:0] operand_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(DATA_W + 1);

    logic sclk_level, sclk_rise_c, sclk_fall_c;
    logic sdi_level,  sdi_rise_c,  sdi_fall_c;
    logic cs_level,   cs_rise_c,   cs_fall_c;

    matrix_operand_loader_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin(sclk_i),
        .level(sclk_level), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    matrix_operand_loader_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .pin(sdi_i),
        .level(sdi_level), .rise_c(sdi_rise_c), .fall_c(sdi_fall_c)
    );

    matrix_operand_loader_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin(cs_n_i),
        .level(cs_level), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    // Only some of the synchroniser outputs are meaningful for each pin.
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_level, sclk_fall_c, sdi_rise_c, sdi_fall_c, cs_level};

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            operand_o <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (!ena) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall_c) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            busy_o  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        // Frame end wins over a coincident sclk edge.
                        if (cs_rise_c) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (bit_cnt == CNT_FULL) begin
                                operand_o <= shreg;
                                valid_o   <= 1'b1;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end else if (sclk_rise_c) begin
                            if (bit_cnt < CNT_FULL) begin
                                shreg <= {shreg[DATA_W-2:0], sdi_level};
                            end
                            if (bit_cnt != CNT_OVERRUN) begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: directed scenarios plus random frames.
module tb_matrix_operand_loader;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned PHASE       = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              sclk_i;
    logic              sdi_i;
    logic              cs_n_i;
    logic [DATA_W-1:0] operand_o;
    logic              valid_o;
    logic              err_o;
    logic              busy_o;

    int vectors    = 0;
    int miscompares = 0;

    int valid_cnt   = 0;
    int err_cnt     = 0;
    int overlap_cnt = 0;
    logic prev_pulse = 1'b0;

    logic [DATA_W-1:0] exp_op;

    matrix_operand_loader #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .sclk_i(sclk_i), .sdi_i(sdi_i), .cs_n_i(cs_n_i),
        .operand_o(operand_o), .valid_o(valid_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping; illegal pulse combinations are tallied for the tasks to check.
    always @(negedge clk) begin
        if (valid_o === 1'b1) valid_cnt <= valid_cnt + 1;
        if (err_o === 1'b1)   err_cnt   <= err_cnt + 1;
        if ((valid_o && err_o) || ((valid_o || err_o) && prev_pulse))
            overlap_cnt <= overlap_cnt + 1;
        prev_pulse <= valid_o | err_o;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame();
        cs_n_i = 1'b0;
        step(PHASE);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi_i  = bits[i];
            step(PHASE);
            sclk_i = 1'b1;
            step(PHASE);
            sclk_i = 1'b0;
        end
        step(PHASE);
    endtask

    task automatic end_frame();
        cs_n_i = 1'b1;
        step(PHASE + 2);
    endtask

    task automatic check_frame(input string name, input int v0, input int e0,
                               input int dv, input int de);
        vectors++;
        if (operand_o !== exp_op) begin
            miscompares++;
            $display("FAIL %s operand: got %h expected %h", name, operand_o, exp_op);
        end
        vectors++;
        if (valid_cnt - v0 !== dv) begin
            miscompares++;
            $display("FAIL %s valid pulses: got %0d expected %0d", name, valid_cnt - v0, dv);
        end
        vectors++;
        if (err_cnt - e0 !== de) begin
            miscompares++;
            $display("FAIL %s err pulses: got %0d expected %0d", name, err_cnt - e0, de);
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy after frame: got %b expected 0", name, busy_o);
        end
    endtask

    // Reference rule: a frame commits exactly when it carries DATA_W bits.
    task automatic run_frame(input string name, input logic [15:0] bits, input int n);
        int v0 = valid_cnt;
        int e0 = err_cnt;
        start_frame();
        send_bits(bits, n);
        end_frame();
        if (n == DATA_W) exp_op = bits[DATA_W-1:0];
        check_frame(name, v0, e0, (n == DATA_W) ? 1 : 0, (n == DATA_W) ? 0 : 1);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        got = {operand_o != 0, valid_o, err_o, busy_o};
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_initial: got %b expected 0000", got);
        end
        rst_n = 1'b1;
        step(3);
        start_frame();
        send_bits(16'h000A, 4);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_midframe: got %b expected 1", busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {operand_o != 0, valid_o, err_o, busy_o};
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_async: got %b expected 0000", got);
        end
        cs_n_i = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(PHASE);
        exp_op = '0;
        run_frame("reset_next_frame", 16'h005A, 8);
    endtask

    task automatic test_good_frame();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        start_frame();
        send_bits(16'h00A5, 8);
        cs_n_i = 1'b1;
        step(SYNC_STAGES);
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL good_latency_early: valid got %b expected 0", valid_o);
        end
        step(1);
        vectors++;
        if ({valid_o, operand_o} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL good_latency: valid/operand got %b/%h expected 1/a5", valid_o, operand_o);
        end
        vectors++;
        if ({operand_o[7:4], operand_o[3:0]} !== {4'hA, 4'h5}) begin
            miscompares++;
            $display("FAIL good_nibbles: got %h/%h expected a/5", operand_o[7:4], operand_o[3:0]);
        end
        step(PHASE);
        exp_op = 8'hA5;
        check_frame("good_frame", v0, e0, 1, 0);
    endtask

    task automatic test_short_frame();
        run_frame("short_commit", 16'h00A5, 8);
        run_frame("short_5bit", 16'h0013, 5);
    endtask

    task automatic test_overrun();
        run_frame("overrun_10bit", 16'h0333, 10);
        run_frame("overrun_recover", 16'h003C, 8);
    endtask

    task automatic test_ena_drop();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        start_frame();
        send_bits(16'h0007, 3);
        ena = 1'b0;
        step(1);
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ena_drop_busy: got %b expected 0", busy_o);
        end
        send_bits(16'h001F, 5);
        end_frame();
        check_frame("ena_drop", v0, e0, 0, 0);
        ena = 1'b1;
        step(2);
        run_frame("ena_restore", 16'h0081, 8);
    endtask

    task automatic test_idle_noise();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            sdi_i  = 1'($urandom);
            sclk_i = ~sclk_i;
            step(PHASE);
            vectors++;
            if (busy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_noise_busy[%0d]: got %b expected 0", i, busy_o);
            end
        end
        sclk_i = 1'b0;
        step(PHASE);
        check_frame("idle_noise", v0, e0, 0, 0);
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 30; i++) begin
            int n;
            logic [15:0] bits;
            n    = ($urandom_range(0, 1) == 1) ? DATA_W : int'($urandom_range(0, 11));
            bits = 16'($urandom);
            run_frame($sformatf("random[%0d]", i), bits, n);
        end
    endtask

    task automatic test_pulse_rules();
        vectors++;
        if (overlap_cnt !== 0) begin
            miscompares++;
            $display("FAIL pulse_rules: got %0d violations expected 0", overlap_cnt);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        sclk_i = 1'b0;
        sdi_i  = 1'b0;
        cs_n_i = 1'b1;
        exp_op = '0;
        #12;
        test_reset();
        test_good_frame();
        test_short_frame();
        test_overrun();
        test_ena_drop();
        test_idle_noise();
        test_random_frames();
        test_pulse_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
